// File: rtl/lfsr_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_engine
//  Description : Parametrised Fibonacci LFSR with seed load, free-run and
//                counted-burst stepping, zero-seed lockup protection and
//                optional period measurement.
//
//  Parameters  : WIDTH      - LFSR width in bits (3..32)
//                TAPS       - feedback tap mask; bit i set = state bit i
//                             feeds the XOR
//                RESET_SEED - reset value and zero-seed substitute (non-zero)
//                CNT_W      - width of burst_len and period
//
//  Ports       : clk          in   sole clock, rising edge
//                rst          in   synchronous active-high reset
//                load         in   load seed into the state this edge
//                seed         in   value to load (zero is replaced)
//                run          in   free-run stepping while IDLE
//                burst_start  in   start a counted burst (IDLE only)
//                burst_len    in   step count for the burst
//                state_q      out  current LFSR state (never zero)
//                busy         out  high while a burst is in progress
//                done         out  one-cycle pulse at burst completion
//                lockup       out  one-cycle pulse when a zero seed is replaced
//                period       out  measured sequence period
//                period_valid out  period has been measured since last load
//
//  Options     : define LFSR_PERIOD_EN to build the period counter; without
//                it period and period_valid are constant zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_engine #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter logic [WIDTH-1:0] RESET_SEED = 8'h01,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             run,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] state_q,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_state_zero = '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_lockup;
    logic             w_lockup_nxt;
    logic             w_step;

    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    // ------------------------------------------------------------------
    // Datapath: one Fibonacci step and the sanitised load value
    // ------------------------------------------------------------------
    assign w_fb    = ^(r_state & TAPS);
    assign w_shift = {r_state[WIDTH-2:0], w_fb};

    // A non-maximal tap mask can shift a lone MSB out and land on zero,
    // which would lock the register forever; restart from the seed instead.
    assign w_step_val = (w_shift == c_state_zero) ? RESET_SEED : w_shift;

    assign w_load_val = (seed == c_state_zero) ? RESET_SEED : seed;

    // ------------------------------------------------------------------
    // Next-state / control logic
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        w_lockup_nxt    = 1'b0;
        w_step          = 1'b0;
        w_state_nxt     = r_state;

        if (load) begin
            // Load wins over everything but reset and silently aborts a burst.
            w_state_nxt     = w_load_val;
            w_lockup_nxt    = (seed == c_state_zero);
            w_fsm_nxt       = S_IDLE;
            w_remaining_nxt = c_cnt_zero;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (burst_start) begin
                        if (burst_len != c_cnt_zero) begin
                            w_fsm_nxt       = S_BURST;
                            w_remaining_nxt = burst_len;
                        end else begin
                            // Empty burst: acknowledge without stepping.
                            w_done_nxt = 1'b1;
                        end
                    end else if (run) begin
                        w_step = 1'b1;
                    end
                end
                S_BURST: begin
                    w_step          = 1'b1;
                    w_remaining_nxt = r_remaining - c_cnt_one;
                    if (r_remaining == c_cnt_one) begin
                        w_fsm_nxt  = S_IDLE;
                        w_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_fsm_nxt       = S_IDLE;
                    w_remaining_nxt = c_cnt_zero;
                end
            endcase

            if (w_step) begin
                w_state_nxt = w_step_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= RESET_SEED;
            r_remaining <= c_cnt_zero;
            r_done      <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
            r_lockup    <= w_lockup_nxt;
        end
    end

    assign state_q = r_state;
    assign busy    = (r_fsm == S_BURST);
    assign done    = r_done;
    assign lockup  = r_lockup;

    // ------------------------------------------------------------------
    // Optional period measurement
    // ------------------------------------------------------------------
`ifdef LFSR_PERIOD_EN
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_capture;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;

    // Saturating increment so very long periods pin at all-ones.
    assign w_cnt_inc = (&r_step_cnt) ? r_step_cnt : (r_step_cnt + c_cnt_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt     <= c_cnt_zero;
            r_capture      <= RESET_SEED;
            r_period       <= c_cnt_zero;
            r_period_valid <= 1'b0;
        end else if (load) begin
            r_step_cnt     <= c_cnt_zero;
            r_capture      <= w_load_val;
            r_period       <= c_cnt_zero;
            r_period_valid <= 1'b0;
        end else if (w_step) begin
            r_step_cnt <= w_cnt_inc;
            // First return to the captured value fixes the period; it then
            // holds until the next load or reset.
            if (!r_period_valid && (w_step_val == r_capture)) begin
                r_period       <= w_cnt_inc;
                r_period_valid <= 1'b1;
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
`else
    assign period       = c_cnt_zero;
    assign period_valid = 1'b0;
`endif

endmodule
`default_nettype wire
